mem_port_arbiter: RTL

- Shares one single-ported memory interface between the instruction fetch unit (IFU) and the load/store unit (LSU) of the NPC core.
- Accepts one request at a time, forwards it to memory, and routes the response back to the requester that owns it.
- At most one transaction outstanding.
- Default policy: fixed priority, LSU first, with an IFU starvation limit.

---
 rtl/mem_port_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory interface between the
// instruction fetch unit (IFU) and the load/store unit (LSU) of the NPC core.
// One transaction is outstanding at a time. Requests are latched on accept,
// presented to memory until it takes them, and the response is routed back
// to the requester that owns the transaction.
//
// Arbitration policy:
//   default            : fixed priority, LSU first. After STARVE_MAX
//                        consecutive LSU grants while the IFU is waiting,
//                        the IFU is forced through.
//   MEM_ARB_RR_EN      : round-robin. The requester that did not win last
//                        time wins a tie. The IFU wins the first tie after
//                        reset. STARVE_MAX is not used in this build.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  ifu_req_valid,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_req_ready,
    output logic                  ifu_rsp_valid,
    output logic [DATA_W-1:0]     ifu_rsp_data,

    input  logic                  lsu_req_valid,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   lsu_req_wmask,
    output logic                  lsu_req_ready,
    output logic                  lsu_rsp_valid,
    output logic [DATA_W-1:0]     lsu_rsp_data,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_data
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_t;

    state_t              state;
    state_t              state_next;
    owner_t              owner;

    logic [ADDR_W-1:0]   lat_addr;
    logic                lat_wen;
    logic [DATA_W-1:0]   lat_wdata;
    logic [MASK_W-1:0]   lat_wmask;

    logic                grant_ifu;
    logic                grant_lsu;
    logic                accept;

    // A request is accepted only in IDLE, and only for the arbitration winner.
    assign accept = (state == ST_IDLE) && (grant_ifu || grant_lsu);

`ifdef MEM_ARB_RR_EN

    owner_t last_grant;

    // Round-robin: on a tie the requester that lost last time goes first.
    always_comb begin
        grant_ifu = ifu_req_valid && (!lsu_req_valid || (last_grant == OWN_LSU));
        grant_lsu = lsu_req_valid && !grant_ifu;
    end

    // Remember who won the most recent accept; LSU at reset so the IFU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= OWN_LSU;
        end else if (accept) begin
            last_grant <= grant_lsu ? OWN_LSU : OWN_IFU;
        end
    end

`else

    localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             ifu_forced;

    // Fixed LSU-first priority, overridden once the IFU has been passed over STARVE_MAX times.
    always_comb begin
        ifu_forced = ifu_req_valid && (starve_cnt == CNT_MAX);
        grant_lsu  = lsu_req_valid && !ifu_forced;
        grant_ifu  = ifu_req_valid && !grant_lsu;
    end

    // Count LSU grants that bypassed a waiting IFU; any IFU grant starts the count over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (accept) begin
            if (grant_ifu) begin
                starve_cnt <= '0;
            end else if (ifu_req_valid && (starve_cnt != CNT_MAX)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

`endif

    // Transaction state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the winning request's fields and owner; IFU fetches are always reads with no mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr  <= '0;
            lat_wen   <= 1'b0;
            lat_wdata <= '0;
            lat_wmask <= '0;
            owner     <= OWN_IFU;
        end else if (accept) begin
            if (grant_lsu) begin
                lat_addr  <= lsu_req_addr;
                lat_wen   <= lsu_req_wen;
                lat_wdata <= lsu_req_wdata;
                lat_wmask <= lsu_req_wmask;
                owner     <= OWN_LSU;
            end else begin
                lat_addr  <= ifu_req_addr;
                lat_wen   <= 1'b0;
                lat_wdata <= '0;
                lat_wmask <= '0;
                owner     <= OWN_IFU;
            end
        end
    end

    // Next-state and handshake outputs; responses outside WAIT are ignored.
    always_comb begin
        state_next    = state;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;

        case (state)
            ST_IDLE: begin
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
                if (accept) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    ifu_rsp_valid = (owner == OWN_IFU);
                    lsu_rsp_valid = (owner == OWN_LSU);
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mem_req_addr  = lat_addr;
    assign mem_req_wen   = lat_wen;
    assign mem_req_wdata = lat_wdata;
    assign mem_req_wmask = lat_wmask;

    assign ifu_rsp_data  = mem_rsp_data;
    assign lsu_rsp_data  = mem_rsp_data;

endmodule
